router_ctrl_fsm: RTL and testbench
==================================

// Module: router_ctrl_fsm
// PURPOSE
//  Control FSM of the 1x3 router: sequences the packet register block and the output FIFOs.
//  Decodes the header address and generates the load strobes: detect_add, lfd_state, ld_state,
//  laf_state, full_state and rst_int_reg. Generates the FIFO write enable and the busy back-pressure
//  to the source. Sits between the source interface, router_reg and the per-port FIFOs/sync logic.
// PARAMETERS
//  NPORT   3  number of output ports/FIFOs; header addresses >= NPORT are invalid
//  ADDR_W  2  width of header address field data_in[ADDR_W-1:0]
// PORTS
//  clock          in   1       system clock, all state on rising edge
//  resetn         in   1       asynchronous, active-low reset
//  pkt_valid      in   1       source packet valid (high header..last payload, low on parity byte)
//  data_in        in   ADDR_W  header address bits (data_in[1:0] of the byte bus)
//  fifo_full      in   1       full flag of the currently addressed FIFO
//  fifo_empty     in   NPORT   per-port FIFO empty flags
//  soft_reset     in   NPORT   per-port soft reset (read-timeout) from sync block
//  parity_done    in   1       from router_reg: parity byte captured
//  low_pkt_valid  in   1       from router_reg: pkt_valid seen low during load
//  write_enb_reg  out  1       FIFO write enable for current byte
//  detect_add     out  1       state DECODE_ADDRESS
//  lfd_state      out  1       state LOAD_FIRST_DATA (header byte written)
//  ld_state       out  1       state LOAD_DATA
//  laf_state      out  1       state LOAD_AFTER_FULL
//  full_state     out  1       state FIFO_FULL_STATE
//  rst_int_reg    out  1       state CHECK_PARITY_ERROR (clears low_pkt_valid in router_reg)
//  busy           out  1       source must hold data_in
//  cur_addr       out  ADDR_W  latched destination address
// BEHAVIOUR
//  - States (one-hot or binary, 8): DECODE_ADDRESS(DA), LOAD_FIRST_DATA(LFD), LOAD_DATA(LD),
//    WAIT_TILL_EMPTY(WTE), FIFO_FULL_STATE(FFS), LOAD_AFTER_FULL(LAF), LOAD_PARITY(LP),
//    CHECK_PARITY_ERROR(CPE).
//  - Reset (resetn=0, async): state=DA, cur_addr=0. Outputs therefore: detect_add=1, all others 0.
//  - All outputs are Moore decodes of registered state; no combinational input->output path.
//  - cur_addr <= data_in in DA when pkt_valid=1 and data_in<NPORT; held in all other states.
//  - Transitions (evaluated each rising edge; first match wins):
//    * any state: soft_reset[cur_addr]=1 -> DA (highest priority, overrides all below).
//    * DA:  pkt_valid & data_in<NPORT & fifo_empty[data_in]  -> LFD
//           pkt_valid & data_in<NPORT & !fifo_empty[data_in] -> WTE
//           otherwise (incl. invalid address) stay DA; invalid header is dropped.
//    * LFD: -> LD unconditionally (exactly one cycle).
//    * LD:  fifo_full -> FFS; else !pkt_valid -> LP; else stay.
//    * FFS: !fifo_full -> LAF; else stay.
//    * LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
//    * LP:  -> CPE unconditionally.
//    * CPE: fifo_full -> FFS; else -> DA.
//    * WTE: fifo_empty[cur_addr] -> LFD; else stay.
//  - write_enb_reg = LFD|LD|LAF|LP. busy = 1 in LFD,WTE,FFS,LAF,LP,CPE; 0 in DA and LD.
//  - Latency: header accepted in DA at edge N -> lfd_state high after edge N, ld_state after N+1.
//  - fifo_full and pkt_valid low in same LD cycle: fifo_full wins (-> FFS); parity path via LAF.
//  - soft_reset on a non-addressed port is ignored. Reset mid-packet: immediate DA, strobes low.
// TESTING
//  1 reset: resetn=0 async mid-cycle -> detect_add=1, busy=0, write_enb_reg=0 before next edge.
//  2 good packet addr=1, fifo_empty=3'b111, 4 payloads then pkt_valid=0 -> DA,LFD,LD x4,LP,CPE,DA;
//    write_enb_reg high 6 cycles; rst_int_reg high 1 cycle; cur_addr=1.
//  3 addr=2, fifo_empty=3'b011 -> WTE, busy=1; set fifo_empty[2]=1 -> LFD next edge.
//  4 fifo_full=1 during LD for 3 cycles -> FFS held 3 cycles, busy=1, write_enb_reg=0; then LAF;
//    with low_pkt_valid=0,parity_done=0 -> LD; with low_pkt_valid=1 -> LP.
//  5 header addr=3 with pkt_valid=1 -> stays DA, no write_enb_reg, cur_addr unchanged.
//  6 soft_reset[1]=1 in WTE (cur_addr=1) -> DA next edge; soft_reset[0]=1 instead -> no change.

Source files
------------

// File: rtl/router_ctrl_fsm.sv
// Control FSM of the 1x3 router: decodes the header address, sequences the
// packet register load strobes, FIFO write enable and busy back-pressure.
module router_ctrl_fsm #(
    parameter int NPORT  = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NPORT-1:0]  fifo_empty,
    input  logic [NPORT-1:0]  soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              write_enb_reg,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_addr
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        WTE = 3'd3,
        FFS = 3'd4,
        LAF = 3'd5,
        LP  = 3'd6,
        CPE = 3'd7
    } state_e;

    localparam int                NSLOT   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   NPORT_W = (ADDR_W+1)'(NPORT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

    // Flags widened to the full address space so any address can index them;
    // slots beyond NPORT read as 0.
    logic [NSLOT-1:0]  empty_ext;
    logic [NSLOT-1:0]  srst_ext;

    for (genvar i = 0; i < NSLOT; i++) begin : g_ext
        if (i < NPORT) begin : g_port
            assign empty_ext[i] = fifo_empty[i];
            assign srst_ext[i]  = soft_reset[i];
        end else begin : g_none
            assign empty_ext[i] = 1'b0;
            assign srst_ext[i]  = 1'b0;
        end
    end

    logic addr_ok;
    logic hdr_ok;
    logic srst_hit;

    assign addr_ok  = ({1'b0, data_in} < NPORT_W);
    assign hdr_ok   = pkt_valid & addr_ok;
    assign srst_hit = srst_ext[cur_addr_q];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DA;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        if (state_q == DA && hdr_ok) begin
            cur_addr_d = data_in;
        end
        if (srst_hit) begin
            state_d = DA;
        end else begin
            unique case (state_q)
                DA: begin
                    if (hdr_ok) state_d = empty_ext[data_in] ? LFD : WTE;
                end
                LFD: state_d = LD;
                LD: begin
                    if (fifo_full)       state_d = FFS;
                    else if (!pkt_valid) state_d = LP;
                end
                FFS: begin
                    if (!fifo_full) state_d = LAF;
                end
                LAF: begin
                    if (parity_done)        state_d = DA;
                    else if (low_pkt_valid) state_d = LP;
                    else                    state_d = LD;
                end
                LP:  state_d = CPE;
                CPE: state_d = fifo_full ? FFS : DA;
                WTE: begin
                    if (empty_ext[cur_addr_q]) state_d = LFD;
                end
                default: state_d = DA;
            endcase
        end
    end

    always_comb begin
        detect_add    = (state_q == DA);
        lfd_state     = (state_q == LFD);
        ld_state      = (state_q == LD);
        laf_state     = (state_q == LAF);
        full_state    = (state_q == FFS);
        rst_int_reg   = (state_q == CPE);
        write_enb_reg = (state_q == LFD) || (state_q == LD) ||
                        (state_q == LAF) || (state_q == LP);
        busy          = !((state_q == DA) || (state_q == LD));
        cur_addr      = cur_addr_q;
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Bench for router_ctrl_fsm: directed vector table, hand sequences for reset,
// then randomized traffic against a rule-level reference model.
module tb_router_ctrl_fsm;

    localparam int NPORT  = 3;
    localparam int ADDR_W = 2;

    // Model state identifiers (independent of the DUT encoding)
    localparam int M_DA = 0, M_LFD = 1, M_LD = 2, M_WTE = 3,
                   M_FFS = 4, M_LAF = 5, M_LP = 6, M_CPE = 7;

    logic              clock = 1'b0;
    logic              resetn;
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic [NPORT-1:0]  fifo_empty;
    logic [NPORT-1:0]  soft_reset;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              write_enb_reg, detect_add, lfd_state, ld_state;
    logic              laf_state, full_state, rst_int_reg, busy;
    logic [ADDR_W-1:0] cur_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int m_st;
    logic [ADDR_W-1:0] m_addr;
    int we_cnt, rst_cnt;

    router_ctrl_fsm #(.NPORT(NPORT), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy), .cur_addr(cur_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              pv;
        logic [ADDR_W-1:0] din;
        logic              full;
        logic [NPORT-1:0]  empty;
        logic [NPORT-1:0]  srst;
        logic              pd;
        logic              lpv;
        int                st;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t vecs[$];

    // Outputs packed as {we, da, lfd, ld, laf, ffs, rst_int, busy, addr}
    function automatic logic [7+ADDR_W:0] exp_of(int st, logic [ADDR_W-1:0] a);
        logic we, by;
        we = (st == M_LFD) || (st == M_LD) || (st == M_LAF) || (st == M_LP);
        by = (st != M_DA) && (st != M_LD);
        return {we, st == M_DA, st == M_LFD, st == M_LD, st == M_LAF,
                st == M_FFS, st == M_CPE, by, a};
    endfunction

    function automatic logic [7+ADDR_W:0] dut_out();
        return {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                full_state, rst_int_reg, busy, cur_addr};
    endfunction

    task automatic check(input string name, input logic [7+ADDR_W:0] exp);
        logic [7+ADDR_W:0] act;
        act = dut_out();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [ADDR_W-1:0] din, input logic full,
                         input logic [NPORT-1:0] empty, input logic [NPORT-1:0] srst,
                         input logic pd, input logic lpv);
        pkt_valid = pv; data_in = din; fifo_full = full; fifo_empty = empty;
        soft_reset = srst; parity_done = pd; low_pkt_valid = lpv;
    endtask

    // Reference model: one clock of the router control rules
    task automatic model_step();
        int nx;
        logic hdr;
        hdr = pkt_valid && (int'(data_in) < NPORT);
        nx = m_st;
        if (m_addr < NPORT && soft_reset[m_addr]) nx = M_DA;
        else if (m_st == M_DA) begin
            if (hdr) nx = fifo_empty[data_in] ? M_LFD : M_WTE;
        end
        else if (m_st == M_LFD) nx = M_LD;
        else if (m_st == M_LD)  nx = fifo_full ? M_FFS : (!pkt_valid ? M_LP : M_LD);
        else if (m_st == M_FFS) nx = fifo_full ? M_FFS : M_LAF;
        else if (m_st == M_LAF) nx = parity_done ? M_DA : (low_pkt_valid ? M_LP : M_LD);
        else if (m_st == M_LP)  nx = M_CPE;
        else if (m_st == M_CPE) nx = fifo_full ? M_FFS : M_DA;
        else if (m_st == M_WTE) nx = fifo_empty[m_addr] ? M_LFD : M_WTE;
        if (m_st == M_DA && hdr) m_addr = data_in;
        m_st = nx;
    endtask

    task automatic add(input logic pv, input logic [ADDR_W-1:0] din, input logic full,
                       input logic [NPORT-1:0] empty, input logic [NPORT-1:0] srst,
                       input logic pd, input logic lpv, input int st, input logic [ADDR_W-1:0] a);
        vec_t v;
        v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.srst = srst;
        v.pd = pd; v.lpv = lpv; v.st = st; v.addr = a;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        m_st = M_DA; m_addr = '0;
    endtask

    initial begin
        resetn = 1'b1;
        drive(0, 0, 0, 3'b111, 3'b000, 0, 0);
        #2 resetn = 1'b0;
        #1 check("reset_state", exp_of(M_DA, 2'd0));
        do_reset();

        // Good packet to port 1: header, 4 payloads, parity
        add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, M_LFD, 2'd1);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_LD,  2'd1);
        add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, M_LD,  2'd1);
        add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, M_LD,  2'd1);
        add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, M_LD,  2'd1);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_LP,  2'd1);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_CPE, 2'd1);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_DA,  2'd1);
        // Port 2 busy: wait till empty, then load
        add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, M_WTE, 2'd2);
        add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, M_WTE, 2'd2);
        add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, M_LFD, 2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_LD,  2'd2);
        // FIFO full for 3 LD cycles, then LAF -> LD
        add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, M_FFS, 2'd2);
        add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, M_FFS, 2'd2);
        add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, M_FFS, 2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_LAF, 2'd2);
        add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_LD,  2'd2);
        // full and pkt_valid low together: full wins, parity via LAF
        add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, M_FFS, 2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, M_LAF, 2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, M_LP,  2'd2);
        add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, M_CPE, 2'd2);
        add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, M_FFS, 2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, M_LAF, 2'd2);
        add(0, 2'd0, 0, 3'b111, 3'b000, 1, 0, M_DA,  2'd2);
        // Invalid header address dropped
        add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, M_DA,  2'd2);
        add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, M_DA,  2'd2);
        // Soft reset: other port ignored, addressed port aborts
        add(1, 2'd1, 0, 3'b101, 3'b000, 0, 0, M_WTE, 2'd1);
        add(0, 2'd0, 0, 3'b101, 3'b001, 0, 0, M_WTE, 2'd1);
        add(0, 2'd0, 0, 3'b101, 3'b010, 0, 0, M_DA,  2'd1);

        we_cnt = 0; rst_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pv, vecs[i].din, vecs[i].full, vecs[i].empty,
                  vecs[i].srst, vecs[i].pd, vecs[i].lpv);
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), exp_of(vecs[i].st, vecs[i].addr));
            if (i < 8) begin
                we_cnt  += int'(write_enb_reg);
                rst_cnt += int'(rst_int_reg);
            end
        end
        n_cmp++;
        if (we_cnt != 6 || rst_cnt != 1) begin
            n_bad++;
            $display("FAIL pkt_strobe_count: we=%0d rst_int=%0d expected we=6 rst_int=1", we_cnt, rst_cnt);
        end

        // Asynchronous reset mid-packet, checked before the next edge
        drive(1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_async_ld", exp_of(M_LD, 2'd0));
        #2 resetn = 1'b0;
        #1 check("async_reset", exp_of(M_DA, 2'd0));
        @(posedge clock); #1;
        check("reset_hold", exp_of(M_DA, 2'd0));
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, ADDR_W'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 2, NPORT'($urandom), 
                  ($urandom_range(0, 19) == 0) ? NPORT'($urandom) : '0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
            model_step();
            @(posedge clock); #1;
            check($sformatf("rnd%0d", i), exp_of(m_st, m_addr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
